// File: rtl/sccb_pkg.sv
// Shared SCCB definitions used by the responder, the master FSM and the
// timing generator.
//   sccb_state_e      responder protocol states
//   SCCB_* constants  phase length, bit indices and idle line level
//   sccb_is_start/stop  bus condition decode from a line sample and its history
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUBADDR,
    ST_SUBADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_NA,
    ST_IGNORE
  } sccb_state_e;

  localparam int         SCCB_BITS_PER_PHASE = 9;
  // bit counter value once all data bits of a phase have been clocked
  localparam logic [3:0] SCCB_DATA_BITS      = 4'(SCCB_BITS_PER_PHASE - 1);
  // counter value on the rising edge that samples the last data bit
  localparam logic [3:0] SCCB_LAST_RX_IDX    = 4'(SCCB_BITS_PER_PHASE - 2);
  localparam logic       SCCB_LINE_IDLE      = 1'b1;

  // START: data falls while clock stays high
  function automatic logic sccb_is_start(input logic sc, input logic sc_q,
                                         input logic sd, input logic sd_q);
    return sc && sc_q && sd_q && !sd;
  endfunction

  // STOP: data rises while clock stays high
  function automatic logic sccb_is_stop(input logic sc, input logic sc_q,
                                        input logic sd, input logic sd_q);
    return sc && sc_q && !sd_q && sd;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizers for SIO_C / SIO_D plus bus event decode.
//   clk, rst         system clock, async active-high reset
//   sio_c, sio_d     raw bus lines
//   sd               synchronized data line
//   start, stop      one-clk bus condition pulses
//   sc_rise, sc_fall one-clk clock edge pulses (sample / drive points)
module sccb_line_sync
  import sccb_pkg::*;
#(
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sio_c,
  input  logic sio_d,
  output logic sd,
  output logic start,
  output logic stop,
  output logic sc_rise,
  output logic sc_fall
);

  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic                   sc, sc_q, sd_q;

  // reset to the idle (pulled-up) level so leaving reset on an idle bus
  // produces no events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      sc_q   <= SCCB_LINE_IDLE;
      sd_q   <= SCCB_LINE_IDLE;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d};
      sc_q   <= sc;
      sd_q   <= sd;
    end
  end

  assign sc      = c_sync[SYNC_STAGES-1];
  assign sd      = d_sync[SYNC_STAGES-1];
  assign start   = sccb_is_start(sc, sc_q, sd, sd_q);
  assign stop    = sccb_is_stop(sc, sc_q, sd, sd_q);
  assign sc_rise = sc && !sc_q;
  assign sc_fall = !sc && sc_q;

endmodule

// File: rtl/sccb_slave_responder.sv
// SCCB target-side responder: decodes 3-phase write, 2-phase write and
// 2-phase read cycles and exposes a simple register-file port.
//   clk, rst                 system clock (>= 8x SIO_C), async active-high reset
//   sio_c_i, sio_d_i         bus lines as seen at the pad
//   sio_d_o, sio_d_oe_o      SIO_D drive value / enable (pad built above)
//   reg_waddr_o/wdata_o/wen_o  write port, wen is a one-clk strobe
//   reg_raddr_o, reg_rdata_i current sub-address and its combinational data
//   busy_o                   addressed transaction in progress
module sccb_slave_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] SLV_ID      = 7'h21,
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 8,
  parameter bit         ACK_EN      = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sio_c_i,
  input  logic              sio_d_i,
  output logic              sio_d_o,
  output logic              sio_d_oe_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_wen_o,
  output logic [ADDR_W-1:0] reg_raddr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o
);

  logic sd, start, stop, sc_rise, sc_fall;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .sio_c   (sio_c_i),
    .sio_d   (sio_d_i),
    .sd      (sd),
    .start   (start),
    .stop    (stop),
    .sc_rise (sc_rise),
    .sc_fall (sc_fall)
  );

  sccb_state_e       state, state_nxt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] rx_sh, rx_byte;
  // tx_sh holds the bits still to be driven, MSB next; ones fill behind
  logic [DATA_W-1:0] tx_sh;
  logic              id_match, byte_full, last_rise;
  logic              shift_rx, cnt_inc, cnt_clr, wr_en, sub_ld;
  logic              ack_drive, tx_ld, tx_shift, release_d, busy_set;

  // byte as it will look once the current rising-edge bit is shifted in
  assign rx_byte   = {rx_sh[DATA_W-2:0], sd};
  assign id_match  = (rx_sh[DATA_W-1:1] == SLV_ID);
  assign byte_full = (bit_cnt == SCCB_DATA_BITS);
  assign last_rise = sc_rise && (bit_cnt == SCCB_LAST_RX_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_rx  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    wr_en     = 1'b0;
    sub_ld    = 1'b0;
    ack_drive = 1'b0;
    tx_ld     = 1'b0;
    tx_shift  = 1'b0;
    release_d = 1'b0;
    busy_set  = 1'b0;
    if (start) begin
      state_nxt = ST_ID;
      cnt_clr   = 1'b1;
      release_d = 1'b1;
    end else if (stop) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
      release_d = 1'b1;
    end else begin
      shift_rx = sc_rise && !byte_full && (state inside {ST_ID, ST_SUBADDR, ST_WDATA});
      cnt_inc  = shift_rx || (state == ST_RDATA && sc_rise && !byte_full);
      case (state)
        ST_ID: begin
          if (sc_fall && byte_full) begin
            if (id_match) begin
              state_nxt = ST_ID_ACK;
              ack_drive = 1'b1;
              busy_set  = 1'b1;
            end else begin
              state_nxt = ST_IGNORE;
            end
          end
        end
        ST_ID_ACK: begin
          // 9th rise wraps the counter; R/W still sits in rx_sh[0]
          cnt_clr = sc_rise;
          if (sc_fall) begin
            if (rx_sh[0]) begin
              state_nxt = ST_RDATA;
              tx_ld     = 1'b1;
            end else begin
              state_nxt = ST_SUBADDR;
              release_d = 1'b1;
            end
          end
        end
        ST_SUBADDR: begin
          sub_ld = last_rise;
          if (sc_fall && byte_full) begin
            state_nxt = ST_SUBADDR_ACK;
            ack_drive = 1'b1;
          end
        end
        ST_SUBADDR_ACK: begin
          cnt_clr = sc_rise;
          if (sc_fall) begin
            state_nxt = ST_WDATA;
            release_d = 1'b1;
          end
        end
        ST_WDATA: begin
          wr_en = last_rise;
          if (sc_fall && byte_full) begin
            state_nxt = ST_WDATA_ACK;
            ack_drive = 1'b1;
          end
        end
        ST_WDATA_ACK: begin
          cnt_clr = sc_rise;
          if (sc_fall) begin
            // no auto-increment: further bytes are ignored and not acked
            state_nxt = ST_IGNORE;
            release_d = 1'b1;
          end
        end
        ST_RDATA: begin
          if (sc_fall) begin
            if (byte_full) begin
              state_nxt = ST_RDATA_NA;
              release_d = 1'b1;
            end else begin
              tx_shift = 1'b1;
            end
          end
        end
        ST_RDATA_NA: begin
          // master's NA level is irrelevant: one byte per read, no burst
          if (sc_rise) begin
            state_nxt = ST_IGNORE;
            cnt_clr   = 1'b1;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // SIO_D only changes on sc_fall/start/stop strobes, i.e. with sc low or
  // while releasing, so the responder cannot fake a START/STOP itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '1;
      sio_d_oe_o  <= 1'b0;
      sio_d_o     <= 1'b1;
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      reg_raddr_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      reg_wen_o <= wr_en;
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;
      if (shift_rx) rx_sh <= rx_byte;
      if (sub_ld)   reg_raddr_o <= rx_byte[ADDR_W-1:0];
      if (wr_en) begin
        reg_waddr_o <= reg_raddr_o;
        reg_wdata_o <= rx_byte;
      end
      if (start || stop) busy_o <= 1'b0;
      else if (busy_set) busy_o <= 1'b1;
      if (release_d) begin
        sio_d_oe_o <= 1'b0;
        sio_d_o    <= 1'b1;
      end else if (ack_drive) begin
        if (ACK_EN) begin
          sio_d_oe_o <= 1'b1;
          sio_d_o    <= 1'b0;
        end
      end else if (tx_ld) begin
        sio_d_oe_o <= 1'b1;
        sio_d_o    <= reg_rdata_i[DATA_W-1];
        tx_sh      <= {reg_rdata_i[DATA_W-2:0], 1'b1};
      end else if (tx_shift) begin
        sio_d_o <= tx_sh[DATA_W-1];
        tx_sh   <= {tx_sh[DATA_W-2:0], 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave_responder.sv
module tb_sccb_slave_responder;
  localparam int         SYNC = 2;
  localparam logic [6:0] ID   = 7'h21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sc_m = 1'b1;
  logic       m_sd = 1'b1;
  logic       sio_d_line;
  logic       sio_d_o, sio_d_oe_o, reg_wen_o, busy_o;
  logic [7:0] reg_waddr_o, reg_wdata_o, reg_raddr_o, reg_rdata_i;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // open-drain bus: either side can pull low
  assign sio_d_line = m_sd & (~sio_d_oe_o | sio_d_o);

  sccb_slave_responder #(
    .SLV_ID(ID), .ADDR_W(8), .DATA_W(8), .ACK_EN(1'b1), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .sio_c_i(sc_m), .sio_d_i(sio_d_line),
    .sio_d_o(sio_d_o), .sio_d_oe_o(sio_d_oe_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .reg_wen_o(reg_wen_o),
    .reg_raddr_o(reg_raddr_o), .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return 8'(a * 8'd37) ^ 8'h5A;
  endfunction

  // register file attached to the DUT port
  bit [7:0]   dut_mem [256];
  bit         dut_valid [256];
  int         wen_cnt = 0;
  int         oe_cycles = 0;
  logic [7:0] last_waddr = 8'h00, last_wdata = 8'h00;

  assign reg_rdata_i = dut_valid[reg_raddr_o] ? dut_mem[reg_raddr_o] : init_val(reg_raddr_o);

  always @(posedge clk) begin
    if (reg_wen_o) begin
      dut_mem[reg_waddr_o]   <= reg_wdata_o;
      dut_valid[reg_waddr_o] <= 1'b1;
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= reg_waddr_o;
      last_wdata <= reg_wdata_o;
    end
    if (sio_d_oe_o) oe_cycles <= oe_cycles + 1;
  end

  // reference model: memory contents and current sub-address pointer
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr = 8'h00;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SIO_C period; sc is left low
  task automatic bit_cycle(input logic v, output logic s_line, output logic s_oe);
    wclk(4); m_sd = v; wclk(4); sc_m = 1'b1; wclk(4);
    s_line = sio_d_line; s_oe = sio_d_oe_o;
    wclk(4); sc_m = 1'b0;
  endtask

  task automatic bus_start;
    m_sd = 1'b1; wclk(4); sc_m = 1'b1; wclk(8); m_sd = 1'b0; wclk(8); sc_m = 1'b0;
  endtask

  task automatic bus_stop;
    wclk(4); m_sd = 1'b0; wclk(4); sc_m = 1'b1; wclk(8); m_sd = 1'b1; wclk(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s, o);
    bit_cycle(1'b1, ack, o);
  endtask

  task automatic read_byte(output logic [7:0] d, output logic na_oe);
    logic s, o;
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s, o);
      acc = {acc[6:0], s};
    end
    bit_cycle(1'b1, s, na_oe);
    d = acc;
  endtask

  // full transaction with expectations derived from the protocol rules
  task automatic run_txn(input string tag, input logic rd, input logic [6:0] id, input int nb,
                         input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                         output logic [7:0] rd_data);
    logic [7:0] bytes [4];
    logic       ack, na_oe, match, exp_ack, do_wr;
    logic [7:0] exp_d;
    int         w0, o0;
    match = (id == ID);
    bytes[0] = {id, rd}; bytes[1] = p1; bytes[2] = p2; bytes[3] = p3;
    do_wr = !rd && match && nb >= 3;
    w0 = wen_cnt; o0 = oe_cycles; rd_data = 8'hFF;
    bus_start;
    write_byte(bytes[0], ack);
    total++; if (ack !== !match) $display("FAIL %s id_ack: got %b want %b", tag, ack, !match); else passed++;
    total++; if (busy_o !== match) $display("FAIL %s busy: got %b want %b", tag, busy_o, match); else passed++;
    if (rd) begin
      exp_d = match ? m_mem[m_ptr] : 8'hFF;
      read_byte(rd_data, na_oe);
      total++; if (rd_data !== exp_d) $display("FAIL %s rdata: got %h want %h", tag, rd_data, exp_d); else passed++;
      total++; if (na_oe !== 1'b0) $display("FAIL %s na_oe: got %b want 0", tag, na_oe); else passed++;
    end else begin
      for (int k = 1; k < nb; k++) begin
        write_byte(bytes[k], ack);
        exp_ack = !(match && k <= 2);
        total++; if (ack !== exp_ack) $display("FAIL %s ack%0d: got %b want %b", tag, k, ack, exp_ack); else passed++;
      end
    end
    bus_stop;
    if (!rd && match && nb >= 2) m_ptr = p1;
    total++; if (wen_cnt - w0 !== (do_wr ? 1 : 0))
      $display("FAIL %s wen_count: got %0d want %0d", tag, wen_cnt - w0, do_wr ? 1 : 0); else passed++;
    if (do_wr) begin
      m_mem[p1] = p2;
      total++; if (last_waddr !== p1 || last_wdata !== p2)
        $display("FAIL %s write: got %h/%h want %h/%h", tag, last_waddr, last_wdata, p1, p2); else passed++;
    end
    if (!match) begin
      total++; if (oe_cycles !== o0) $display("FAIL %s oe_on_mismatch: got %0d cycles want 0", tag, oe_cycles - o0); else passed++;
    end
    total++; if (busy_o !== 1'b0 || reg_raddr_o !== m_ptr)
      $display("FAIL %s post_stop busy/raddr: got %b/%h want 0/%h", tag, busy_o, reg_raddr_o, m_ptr); else passed++;
  endtask

  task automatic test_reset;
    wclk(3);
    total++; if (sio_d_oe_o !== 1'b0 || sio_d_o !== 1'b1)
      $display("FAIL reset_sio: got oe=%b d=%b want 0/1", sio_d_oe_o, sio_d_o); else passed++;
    total++; if (reg_wen_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL reset_ctl: got wen=%b busy=%b want 0/0", reg_wen_o, busy_o); else passed++;
    total++; if (reg_waddr_o !== 8'h00 || reg_wdata_o !== 8'h00 || reg_raddr_o !== 8'h00)
      $display("FAIL reset_regs: got %h/%h/%h want 00/00/00", reg_waddr_o, reg_wdata_o, reg_raddr_o); else passed++;
    rst = 1'b0;
    wclk(4);
    total++; if (sio_d_oe_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL post_reset: got oe=%b busy=%b want 0/0", sio_d_oe_o, busy_o); else passed++;
  endtask

  task automatic test_write3;
    logic [7:0] d;
    run_txn("write3", 1'b0, ID, 3, 8'h12, 8'hA5, 8'h00, d);
    total++; if (last_waddr !== 8'h12 || last_wdata !== 8'hA5)
      $display("FAIL write3_const: got %h/%h want 12/A5", last_waddr, last_wdata); else passed++;
  endtask

  task automatic test_read;
    logic [7:0] d;
    int w0;
    run_txn("read_prep", 1'b0, ID, 3, 8'h0A, 8'h5C, 8'h00, d);
    w0 = wen_cnt;
    run_txn("read_sub", 1'b0, ID, 2, 8'h0A, 8'h00, 8'h00, d);
    run_txn("read", 1'b1, ID, 1, 8'h00, 8'h00, 8'h00, d);
    total++; if (d !== 8'h5C) $display("FAIL read_const: got %h want 5c", d); else passed++;
    total++; if (wen_cnt !== w0) $display("FAIL read_no_wen: got %0d pulses want 0", wen_cnt - w0); else passed++;
  endtask

  task automatic test_mismatch;
    logic [7:0] d;
    run_txn("mismatch", 1'b0, 7'h30, 3, 8'($urandom), 8'($urandom), 8'h00, d);
  endtask

  task automatic test_stop_mid;
    logic ack, s, o;
    int   w0;
    w0 = wen_cnt;
    bus_start;
    write_byte({ID, 1'b0}, ack);
    write_byte(8'h77, ack);
    m_ptr = 8'h77;
    for (int i = 0; i < 3; i++) bit_cycle(1'b0, s, o);
    wclk(4); m_sd = 1'b0; wclk(4); sc_m = 1'b1; wclk(8); m_sd = 1'b1;
    wclk(SYNC + 2);
    total++; if (sio_d_oe_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL stop_mid_release: got oe=%b busy=%b want 0/0", sio_d_oe_o, busy_o); else passed++;
    wclk(8);
    total++; if (wen_cnt !== w0) $display("FAIL stop_mid_no_wen: got %0d pulses want 0", wen_cnt - w0); else passed++;
    total++; if (reg_raddr_o !== m_ptr) $display("FAIL stop_mid_raddr: got %h want %h", reg_raddr_o, m_ptr); else passed++;
  endtask

  task automatic test_rep_start;
    logic       ack, na_oe;
    logic [7:0] sub, d;
    sub = 8'($urandom);
    bus_start;
    write_byte({ID, 1'b0}, ack);
    write_byte(sub, ack);
    m_ptr = sub;
    bus_start;
    write_byte({ID, 1'b1}, ack);
    total++; if (ack !== 1'b0) $display("FAIL rep_start_ack: got %b want 0", ack); else passed++;
    read_byte(d, na_oe);
    bus_stop;
    total++; if (d !== m_mem[sub]) $display("FAIL rep_start_rdata: got %h want %h", d, m_mem[sub]); else passed++;
  endtask

  task automatic test_rst_mid_read;
    logic       ack;
    logic [7:0] d, a, v;
    bus_start;
    write_byte({ID, 1'b1}, ack);
    wclk(4);
    total++; if (sio_d_oe_o !== 1'b1) $display("FAIL rst_mid_pre_oe: got %b want 1", sio_d_oe_o); else passed++;
    rst = 1'b1;
    #1;
    total++; if (sio_d_oe_o !== 1'b0 || sio_d_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL rst_mid_async: got oe=%b d=%b busy=%b want 0/1/0", sio_d_oe_o, sio_d_o, busy_o); else passed++;
    total++; if (reg_raddr_o !== 8'h00 || reg_waddr_o !== 8'h00 || reg_wdata_o !== 8'h00 || reg_wen_o !== 1'b0)
      $display("FAIL rst_mid_regs: got %h/%h/%h/%b want 00/00/00/0", reg_raddr_o, reg_waddr_o, reg_wdata_o, reg_wen_o); else passed++;
    m_ptr = 8'h00;
    wclk(3);
    rst = 1'b0;
    m_sd = 1'b1; wclk(4); sc_m = 1'b1; wclk(8);
    a = 8'($urandom); v = 8'($urandom);
    run_txn("after_rst_wr", 1'b0, ID, 3, a, v, 8'h00, d);
    run_txn("after_rst_rd", 1'b1, ID, 1, 8'h00, 8'h00, 8'h00, d);
    total++; if (d !== v) $display("FAIL after_rst_readback: got %h want %h", d, v); else passed++;
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       rd;
    logic [6:0] id;
    for (int t = 0; t < 30; t++) begin
      rd = ($urandom_range(0, 2) == 0);
      id = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ID;
      run_txn("random", rd, id, int'($urandom_range(1, 4)), 8'($urandom), 8'($urandom), 8'($urandom), d);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(8'(i));
    test_reset;
    test_write3;
    test_read;
    test_mismatch;
    test_stop_mid;
    test_rep_start;
    test_rst_mid_read;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
